nexus_ram_ctrl: RTL and testbench
=================================

// Module: nexus_ram_ctrl
// PURPOSE
//   Parametrised single-port synchronous data RAM with valid/ready request handshake,
//   per-byte write enables, configurable read latency (1 or 2) and a hardware clear
//   engine that zero-fills the array after reset or on demand. Sits between the LSU
//   and the data memory array; replaces the plain always-ready RAM for data space.
// PARAMETERS
//   DATA_WIDTH      16  word width in bits; must be a multiple of 8
//   ADDR_WIDTH      15  word address width; depth = 2**ADDR_WIDTH
//   READ_LATENCY    1   cycles from read accept to rsp_valid; legal values 1 or 2
//   CLEAR_ON_RESET  1   1: zero-fill whole array after rst_n release; 0: skip
// PORTS
//   clk        in   1              rising-edge clock
//   rst_n      in   1              asynchronous active-low reset
//   req_valid  in   1              request present
//   req_ready  out  1              controller can accept a request this cycle
//   req_we     in   1              1 = write, 0 = read
//   req_be     in   DATA_WIDTH/8   byte-lane write enables (bit i -> din[8i+7:8i])
//   req_addr   in   ADDR_WIDTH     word address
//   req_wdata  in   DATA_WIDTH     write data
//   rsp_valid  out  1              one-cycle pulse: rsp_rdata holds read result
//   rsp_rdata  out  DATA_WIDTH     read data; holds last value while rsp_valid=0
//   clr_req    in   1              pulse: request full zero-fill of the array
//   init_done  out  1              1 = array usable; 0 during any clear
// BEHAVIOUR
// - Reset (rst_n=0, async): req_ready=0, rsp_valid=0, rsp_rdata=0, init_done=0,
//   read pipeline flushed, clear counter=0, FSM=INIT (CLEAR_ON_RESET=1) or RUN (=0).
//   Array contents are not reset; only the clear engine zeroes them.
// - FSM states: INIT, RUN, DRAIN.
//   INIT : writes 0 to address cnt each cycle, cnt 0 .. 2**ADDR_WIDTH-1; req_ready=0,
//          init_done=0. After writing the last address -> RUN; cnt returns to 0.
//          Clear takes exactly 2**ADDR_WIDTH cycles. clr_req ignored in INIT.
//   RUN  : req_ready=1, init_done=1. clr_req=1 -> DRAIN (takes priority; a request
//          presented that same cycle is not accepted, req_ready already low next cycle).
//   DRAIN: req_ready=0, init_done=0; waits until no read is in flight, then -> INIT.
//          With nothing in flight DRAIN lasts one cycle.
// - Accept = req_valid & req_ready. One request per cycle, no bubbles in RUN.
// - Write accept: for each i with req_be[i]=1, mem[addr] byte i <= wdata byte i at
//   that edge; other lanes unchanged. req_be=0 with req_we=1 is a legal no-op.
//   Writes generate no response.
// - Read accept at edge N: READ_LATENCY=1 -> rsp_valid=1 in cycle N+1;
//   READ_LATENCY=2 -> extra output register, rsp_valid=1 in cycle N+2. Back-to-back
//   reads give back-to-back responses in order. No response backpressure.
// - Write at edge N then read same address at edge N+1 returns the new data.
// - Reset asserted mid-INIT or mid-read: clear restarts from address 0 after release
//   (CLEAR_ON_RESET=1); in-flight responses are dropped, never emitted.
// - Address inputs are word addresses; no wrap or range checking beyond ADDR_WIDTH.
// TESTING
// - Reset release, CLEAR_ON_RESET=1, ADDR_WIDTH=4: req_ready/init_done low 16 cycles,
//   then high; reads of all 16 addresses return 0x0000.
// - Write 0xBEEF to addr 3 be=2'b11, then be=2'b01 wdata 0x1234 -> read addr 3 gives
//   0xBE34; be=2'b00 write leaves 0xBE34.
// - READ_LATENCY=2: reads addr 1,2,3 on consecutive cycles -> rsp_valid high 2..4
//   cycles later, data in request order; LATENCY=1 same stream one cycle earlier.
// - Write 0xA5A5 to addr 7 at cycle N, read addr 7 at N+1 -> rsp_rdata=0xA5A5.
// - Read in flight (LATENCY=2) + clr_req in RUN -> response still delivered, DRAIN
//   then INIT; afterwards addr 3 reads 0x0000.
// - rst_n pulled low halfway through INIT -> outputs to reset values immediately;
//   after release a full 2**ADDR_WIDTH-cycle clear restarts from address 0.

Source files
------------

// File: rtl/nexus_ram_ctrl.sv
// nexus_ram_ctrl: single-port synchronous data RAM behind a valid/ready request port.
// Provides per-byte write enables, a read latency of 1 or 2 cycles and a clear engine
// that zero-fills the whole array after reset release or on a clr_req pulse.
module nexus_ram_ctrl #(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 15,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  input  logic                    clr_req,
  output logic                    init_done
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] CNT_LAST = {ADDR_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Clearing after reset is optional; without it the array is usable at once.
  localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic [ADDR_WIDTH-1:0]   cnt_r;
  logic [DATA_WIDTH-1:0]   mem_r [DEPTH];
  logic                    req_ready_r;
  logic                    init_done_r;
  logic                    rsp_valid_r;
  logic [DATA_WIDTH-1:0]   rsp_rdata_r;
  logic                    ready_nxt_s;
  logic                    done_nxt_s;
  logic                    clr_we_s;
  logic                    acc_s;
  logic                    wr_acc_s;
  logic                    rd_acc_s;
  logic                    pending_s;

  // A clear request wins over a request presented in the same cycle.
  assign acc_s    = req_valid & req_ready_r & ~clr_req;
  assign wr_acc_s = acc_s & req_we;
  assign rd_acc_s = acc_s & ~req_we;

  assign req_ready = req_ready_r;
  assign init_done = init_done_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= RESET_STATE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: clear sweep, normal operation, drain of in-flight reads.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_INIT: begin
        if (cnt_r == CNT_LAST) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_INIT;
        end
      end
      ST_RUN: begin
        if (clr_req) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (pending_s) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_INIT;
        end
      end
      default: begin
        state_nxt_s = ST_INIT;
      end
    endcase
  end

  // Output decode: handshake/status follow the upcoming state, clear writes follow INIT.
  always_comb begin
    ready_nxt_s = 1'b0;
    done_nxt_s  = 1'b0;
    clr_we_s    = 1'b0;
    case (state_nxt_s)
      ST_RUN: begin
        ready_nxt_s = 1'b1;
        done_nxt_s  = 1'b1;
      end
      default: begin
        ready_nxt_s = 1'b0;
        done_nxt_s  = 1'b0;
      end
    endcase
    if (state_r == ST_INIT) begin
      clr_we_s = 1'b1;
    end else begin
      clr_we_s = 1'b0;
    end
  end

  // Registered handshake and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready_r <= 1'b0;
      init_done_r <= 1'b0;
    end else begin
      req_ready_r <= ready_nxt_s;
      init_done_r <= done_nxt_s;
    end
  end

  // Clear address counter: sweeps the array in INIT and wraps back to 0 at the end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {ADDR_WIDTH{1'b0}};
    end else if (state_r == ST_INIT) begin
      cnt_r <= cnt_r + ADDR_WIDTH'(1'b1);
    end else begin
      cnt_r <= {ADDR_WIDTH{1'b0}};
    end
  end

  // Array write port: zero-fill during clear, otherwise byte-lane masked writes.
  always_ff @(posedge clk) begin
    if (clr_we_s) begin
      mem_r[cnt_r] <= {DATA_WIDTH{1'b0}};
    end else if (wr_acc_s) begin
      for (int i = 0; i < BE_WIDTH; i++) begin
        if (req_be[i]) begin
          mem_r[req_addr][8*i +: 8] <= req_wdata[8*i +: 8];
        end
      end
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic                  rd_v1_r;
      logic [DATA_WIDTH-1:0] rd_d1_r;

      assign pending_s = rd_v1_r;

      // First read stage: array read captured on accept.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_v1_r <= 1'b0;
          rd_d1_r <= {DATA_WIDTH{1'b0}};
        end else begin
          rd_v1_r <= rd_acc_s;
          if (rd_acc_s) begin
            rd_d1_r <= mem_r[req_addr];
          end
        end
      end

      // Output stage: response pulse, data held between responses.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rsp_valid_r <= 1'b0;
          rsp_rdata_r <= {DATA_WIDTH{1'b0}};
        end else begin
          rsp_valid_r <= rd_v1_r;
          if (rd_v1_r) begin
            rsp_rdata_r <= rd_d1_r;
          end
        end
      end
    end else begin : g_lat1
      assign pending_s = 1'b0;

      // Single read stage: array read straight into the response register.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rsp_valid_r <= 1'b0;
          rsp_rdata_r <= {DATA_WIDTH{1'b0}};
        end else begin
          rsp_valid_r <= rd_acc_s;
          if (rd_acc_s) begin
            rsp_rdata_r <= mem_r[req_addr];
          end
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_nexus_ram_ctrl.sv
// Bench for nexus_ram_ctrl: two instances (read latency 1 and 2) share one stimulus
// stream; a behavioural memory/response model predicts every cycle's outputs.
module tb_nexus_ram_ctrl;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_we;
  logic [1:0]    req_be;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          clr_req;

  logic          ready1, ready2, rv1, rv2, done1, done2;
  logic [DW-1:0] rd1, rd2;

  nexus_ram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1), .CLEAR_ON_RESET(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready1), .req_we(req_we),
    .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rv1),
    .rsp_rdata(rd1), .clr_req(clr_req), .init_done(done1));

  nexus_ram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(2), .CLEAR_ON_RESET(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready2), .req_we(req_we),
    .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rv2),
    .rsp_rdata(rd2), .clr_req(clr_req), .init_done(done2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int due; logic [DW-1:0] d; } rsp_t;
  typedef struct {
    logic          we;
    logic [1:0]    be;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp;
  } vec_t;

  int            checks = 0;
  int            errors = 0;
  int            edge_n = 0;
  logic [DW-1:0] mem_m [DEPTH];
  rsp_t          q1[$];
  rsp_t          q2[$];
  logic [DW-1:0] last1, last2;
  bit            m_ready;
  bit            m_drain;
  int            m_clear_left;
  bit            ovr_en;
  logic [DW-1:0] ovr_val;
  vec_t          tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %h expected %h", name, edge_n, act, exp);
    end
  endtask

  task automatic model_reset();
    m_ready      = 1'b0;
    m_drain      = 1'b0;
    m_clear_left = DEPTH;
    q1.delete();
    q2.delete();
    last1 = '0;
    last2 = '0;
  endtask

  // Spec-level behaviour at one clock edge.
  task automatic model_edge();
    bit            acc;
    logic [DW-1:0] d;
    rsp_t          r;
    acc = m_ready && req_valid && !clr_req;
    if (m_ready && clr_req) begin
      m_ready = 1'b0;
      m_drain = 1'b1;
    end else if (m_drain) begin
      m_drain      = 1'b0;
      m_clear_left = DEPTH;
    end else if (m_clear_left > 0) begin
      m_clear_left--;
      if (m_clear_left == 0) begin
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
        m_ready = 1'b1;
      end
    end
    if (acc) begin
      if (req_we) begin
        for (int i = 0; i < 2; i++)
          if (req_be[i]) mem_m[req_addr][8*i +: 8] = req_wdata[8*i +: 8];
      end else begin
        d = ovr_en ? ovr_val : mem_m[req_addr];
        r.d = d;
        r.due = edge_n;     q1.push_back(r);
        r.due = edge_n + 1; q2.push_back(r);
      end
    end
  endtask

  task automatic check_outputs();
    bit            ev;
    logic [DW-1:0] ed;
    chk("ready_l1", {31'd0, ready1}, {31'd0, m_ready});
    chk("ready_l2", {31'd0, ready2}, {31'd0, m_ready});
    chk("done_l1",  {31'd0, done1},  {31'd0, m_ready});
    chk("done_l2",  {31'd0, done2},  {31'd0, m_ready});
    ev = (q1.size() > 0) && (q1[0].due == edge_n);
    ed = ev ? q1[0].d : last1;
    chk("rsp_valid_l1", {31'd0, rv1}, {31'd0, ev});
    chk("rsp_rdata_l1", {16'd0, rd1}, {16'd0, ed});
    if (ev) begin last1 = ed; void'(q1.pop_front()); end
    ev = (q2.size() > 0) && (q2[0].due == edge_n);
    ed = ev ? q2[0].d : last2;
    chk("rsp_valid_l2", {31'd0, rv2}, {31'd0, ev});
    chk("rsp_rdata_l2", {16'd0, rd2}, {16'd0, ed});
    if (ev) begin last2 = ed; void'(q2.pop_front()); end
  endtask

  task automatic cycle();
    @(posedge clk);
    edge_n++;
    if (rst_n) model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle();
    req_valid = 1'b0; req_we = 1'b0; req_be = 2'b00; clr_req = 1'b0; ovr_en = 1'b0;
  endtask

  // Counts low-ready cycles until ready rises, bounded.
  task automatic wait_ready(input string name, input int exp_n);
    int n;
    n = 0;
    while (!ready1 && n < 200) begin
      cycle();
      n++;
    end
    chk(name, n, exp_n);
  endtask

  task automatic read(input logic [AW-1:0] a);
    req_valid = 1'b1; req_we = 1'b0; req_be = 2'b00; req_addr = a; req_wdata = '0;
    cycle();
  endtask

  task automatic reset_now();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_ready",  {30'd0, ready1, ready2}, 32'd0);
    chk("rst_done",   {30'd0, done1, done2},   32'd0);
    chk("rst_valid",  {30'd0, rv1, rv2},       32'd0);
    chk("rst_rdata",  {rd1, rd2},              32'd0);
  endtask

  initial begin
    rst_n = 1'b0; req_addr = '0; req_wdata = '0; ovr_val = '0;
    idle();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 16'h0BAD;
    model_reset();

    tbl[0]  = '{1'b1, 2'b11, 4'd3, 16'hBEEF, 16'h0000};
    tbl[1]  = '{1'b1, 2'b01, 4'd3, 16'h1234, 16'h0000};
    tbl[2]  = '{1'b0, 2'b00, 4'd3, 16'h0000, 16'hBE34};
    tbl[3]  = '{1'b1, 2'b00, 4'd3, 16'hFFFF, 16'h0000};
    tbl[4]  = '{1'b0, 2'b00, 4'd3, 16'h0000, 16'hBE34};
    tbl[5]  = '{1'b1, 2'b11, 4'd7, 16'hA5A5, 16'h0000};
    tbl[6]  = '{1'b0, 2'b00, 4'd7, 16'h0000, 16'hA5A5};
    tbl[7]  = '{1'b1, 2'b11, 4'd1, 16'h1111, 16'h0000};
    tbl[8]  = '{1'b1, 2'b11, 4'd2, 16'h2222, 16'h0000};
    tbl[9]  = '{1'b0, 2'b00, 4'd1, 16'h0000, 16'h1111};
    tbl[10] = '{1'b0, 2'b00, 4'd2, 16'h0000, 16'h2222};
    tbl[11] = '{1'b0, 2'b00, 4'd3, 16'h0000, 16'hBE34};
    tbl[12] = '{1'b1, 2'b10, 4'd0, 16'h5AC3, 16'h0000};
    tbl[13] = '{1'b0, 2'b00, 4'd0, 16'h0000, 16'h5A00};

    // Reset held, then released: 16-cycle clear.
    repeat (3) cycle();
    rst_n = 1'b1;
    wait_ready("init_len_reset", 16);

    // Every address reads zero after the clear.
    for (int a = 0; a < DEPTH; a++) read(a[AW-1:0]);
    idle();
    repeat (3) cycle();

    // Directed table: byte lanes, no-op write, write-then-read, back-to-back reads.
    for (int i = 0; i < 14; i++) begin
      req_valid = 1'b1; req_we = tbl[i].we; req_be = tbl[i].be;
      req_addr = tbl[i].addr; req_wdata = tbl[i].wdata;
      ovr_en = !tbl[i].we; ovr_val = tbl[i].exp;
      cycle();
    end
    idle();
    repeat (3) cycle();

    // Read in flight, then clr_req with a competing read that must be ignored.
    read(4'd3);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd5; clr_req = 1'b1;
    cycle();
    idle();
    wait_ready("init_len_clr", 17);
    read(4'd3);
    idle();
    repeat (3) cycle();

    // Reset while a latency-2 read is in flight: no response may escape.
    read(4'd7);
    idle();
    reset_now();
    repeat (2) cycle();
    rst_n = 1'b1;
    repeat (8) cycle();
    // Reset halfway through INIT: full clear restarts.
    reset_now();
    repeat (2) cycle();
    rst_n = 1'b1;
    wait_ready("init_len_restart", 16);

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_we    = $urandom_range(0, 1);
      req_be    = 2'($urandom_range(0, 3));
      req_addr  = 4'($urandom_range(0, DEPTH - 1));
      req_wdata = 16'($urandom);
      clr_req   = ($urandom_range(0, 79) == 0);
      ovr_en    = 1'b0;
      cycle();
    end
    idle();
    repeat (25) cycle();
    chk("queues_empty", q1.size() + q2.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
